// File: rtl/imem_program_loader_pkg.sv
// Shared types and widths for the instruction-memory program loader.
//   loader_state_t   : loader FSM states
//   BYTE_W           : stream byte width
//   HALF_WORD / WORD : instruction and address widths
//   LOADER_HDR_BYTES : length header size in bytes
package imem_program_loader_pkg;

  localparam int unsigned BYTE_W           = 8;
  localparam int unsigned HALF_WORD        = 16;
  localparam int unsigned WORD             = 32;
  localparam int unsigned LOADER_HDR_BYTES = 2;
  localparam int unsigned LEN_W            = LOADER_HDR_BYTES * BYTE_W;

  typedef enum logic [3:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA_LO,
    DATA_HI,
    WRITE,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

  // Little-endian byte pair to half-word.
  function automatic logic [HALF_WORD-1:0] pack_half(input logic [BYTE_W-1:0] hi,
                                                     input logic [BYTE_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/imem_program_loader_if.sv
// Byte-stream and instruction-memory write bus of the program loader.
//   byte_valid_i / byte_i / byte_ready_o        : valid/ready byte stream
//   program_mem_write_en_o / instruction_o /
//   instruction_addr_o                          : memory write port
// slave  : the loader (consumes stream, drives memory port)
// master : the stream source / memory side
interface imem_program_loader_if;
  import imem_program_loader_pkg::*;

  logic                 byte_valid_i;
  logic [BYTE_W-1:0]    byte_i;
  logic                 byte_ready_o;
  logic                 program_mem_write_en_o;
  logic [HALF_WORD-1:0] instruction_o;
  logic [WORD-1:0]      instruction_addr_o;

  modport slave (
    input  byte_valid_i, byte_i,
    output byte_ready_o, program_mem_write_en_o, instruction_o, instruction_addr_o
  );

  modport master (
    output byte_valid_i, byte_i,
    input  byte_ready_o, program_mem_write_en_o, instruction_o, instruction_addr_o
  );

endinterface

// File: rtl/imem_program_loader.sv
// Boot-time loader: takes a length-prefixed byte stream, assembles little-endian
// half-words and writes them into instruction memory while holding the core in reset.
// Ports:
//   clk_i, reset_i (async, active-high)
//   start_i        : begin a load (IDLE, DONE, ERR only)
//   bus            : stream in + memory write port (imem_program_loader_if.slave)
//   cpu_reset_o    : core held in reset while high
//   busy_o         : load in progress
//   load_done_o    : image written, core released
//   load_error_o   : load aborted
// Build option: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  imem_program_loader_if.slave  bus,
  output logic                  cpu_reset_o,
  output logic                  busy_o,
  output logic                  load_done_o,
  output logic                  load_error_o
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned CMP_W = LEN_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  loader_state_t     state_q;
  logic [CNT_W-1:0]  idx_q;
  logic [LEN_W-1:0]  len_q;
  logic [BYTE_W-1:0] lo_q;
`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] xor_q;
`endif

  logic             accept_c;
  logic [LEN_W-1:0] len_c;
  logic             last_c;

  assign accept_c = bus.byte_valid_i && bus.byte_ready_o;
  // Length header is complete when the hi byte arrives; lo byte parked in lo_q.
  assign len_c    = {bus.byte_i, lo_q};
  // Index counter is one bit wider than the address so N == depth terminates cleanly.
  assign last_c   = (CMP_W'(idx_q) + CMP_W'(1)) == {1'b0, len_q};

  // Loader FSM with registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q                    <= IDLE;
      idx_q                      <= '0;
      len_q                      <= '0;
      lo_q                       <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_q                      <= '0;
`endif
      bus.byte_ready_o           <= 1'b0;
      bus.program_mem_write_en_o <= 1'b0;
      bus.instruction_o          <= '0;
      bus.instruction_addr_o     <= WORD'(BASE_ADDR);
      cpu_reset_o                <= 1'b1;
      busy_o                     <= 1'b0;
      load_done_o                <= 1'b0;
      load_error_o               <= 1'b0;
    end else begin
      bus.program_mem_write_en_o <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      if (accept_c) xor_q <= xor_q ^ bus.byte_i;
`endif
      unique case (state_q)
        IDLE, DONE, ERR: begin
          if (start_i) begin
            state_q          <= LEN_LO;
            idx_q            <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q            <= '0;
`endif
            bus.byte_ready_o <= 1'b1;
            cpu_reset_o      <= 1'b1;
            busy_o           <= 1'b1;
            load_done_o      <= 1'b0;
            load_error_o     <= 1'b0;
          end
        end
        LEN_LO: begin
          if (accept_c) begin
            lo_q    <= bus.byte_i;
            state_q <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept_c) begin
            len_q <= len_c;
            if (len_c == '0) begin
`ifdef LOADER_CHECKSUM_EN
              state_q          <= CSUM;
`else
              state_q          <= DONE;
              bus.byte_ready_o <= 1'b0;
              busy_o           <= 1'b0;
              load_done_o      <= 1'b1;
              cpu_reset_o      <= 1'b0;
`endif
            end else if ({1'b0, len_c} > CMP_W'(DEPTH)) begin
              state_q          <= ERR;
              bus.byte_ready_o <= 1'b0;
              busy_o           <= 1'b0;
              load_error_o     <= 1'b1;
            end else begin
              state_q <= DATA_LO;
            end
          end
        end
        DATA_LO: begin
          if (accept_c) begin
            lo_q    <= bus.byte_i;
            state_q <= DATA_HI;
          end
        end
        DATA_HI: begin
          if (accept_c) begin
            bus.program_mem_write_en_o <= 1'b1;
            bus.instruction_o          <= pack_half(bus.byte_i, lo_q);
            bus.instruction_addr_o     <= WORD'(BASE_ADDR) + WORD'(idx_q);
            bus.byte_ready_o           <= 1'b0;
            state_q                    <= WRITE;
          end
        end
        WRITE: begin
          idx_q <= idx_q + CNT_W'(1);
          if (last_c) begin
`ifdef LOADER_CHECKSUM_EN
            state_q          <= CSUM;
            bus.byte_ready_o <= 1'b1;
`else
            state_q          <= DONE;
            busy_o           <= 1'b0;
            load_done_o      <= 1'b1;
            cpu_reset_o      <= 1'b0;
`endif
          end else begin
            state_q          <= DATA_LO;
            bus.byte_ready_o <= 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          // Running XOR over header, data and this byte must cancel to zero.
          if (accept_c) begin
            bus.byte_ready_o <= 1'b0;
            busy_o           <= 1'b0;
            if ((xor_q ^ bus.byte_i) == '0) begin
              state_q     <= DONE;
              load_done_o <= 1'b1;
              cpu_reset_o <= 1'b0;
            end else begin
              state_q      <= ERR;
              load_error_o <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_q          <= IDLE;
          bus.byte_ready_o <= 1'b0;
          busy_o           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Testbench for imem_program_loader: byte-count-based reference model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_imem_program_loader;
  import imem_program_loader_pkg::*;

  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned BASE_ADDR = 0;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b0;
  logic start_i = 1'b0;
  logic cpu_reset_o, busy_o, load_done_o, load_error_o;

  imem_program_loader_if bus();

  imem_program_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .bus         (bus),
    .cpu_reset_o (cpu_reset_o),
    .busy_o      (busy_o),
    .load_done_o (load_done_o),
    .load_error_o(load_error_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the load by number of accepted bytes.
  bit          m_loading = 0, m_done = 0, m_err = 0, m_wr = 0;
  int          m_nbytes = 0, m_len = 0, m_idx = 0;
  logic [7:0]  m_lo = '0, m_xor = '0, m_b;
  logic        e_we = 1'b0;
  logic [15:0] e_instr = '0;
  logic [31:0] e_addr = 32'(BASE_ADDR);

  // Image end reached: either wait for a checksum byte or finish.
  function automatic void m_finish();
`ifndef LOADER_CHECKSUM_EN
    m_loading = 0;
    m_done    = 1;
`endif
  endfunction

  initial forever begin
    @(posedge clk_i or posedge reset_i);
    if (reset_i) begin
      m_loading = 0; m_done = 0; m_err = 0; m_wr = 0;
      e_we = 1'b0; e_instr = '0; e_addr = 32'(BASE_ADDR);
    end else begin
      e_we = 1'b0;
      if (m_wr) begin
        m_wr = 0;
        m_idx++;
        if (m_idx == m_len) m_finish();
      end else if (!m_loading) begin
        if (start_i) begin
          m_loading = 1; m_done = 0; m_err = 0;
          m_nbytes = 0; m_idx = 0; m_xor = '0;
        end
      end else if (bus.byte_valid_i) begin
        m_b = bus.byte_i;
        m_xor ^= m_b;
        m_nbytes++;
        if (m_nbytes == 1) begin
          m_lo = m_b;
        end else if (m_nbytes == 2) begin
          m_len = int'({m_b, m_lo});
          if (m_len == 0) m_finish();
          else if (m_len > (1 << ADDR_W)) begin m_loading = 0; m_err = 1; end
        end else if (m_nbytes - 3 < 2 * m_len) begin
          if (((m_nbytes - 3) % 2) == 0) m_lo = m_b;
          else begin
            e_we = 1'b1; e_instr = {m_b, m_lo};
            e_addr = 32'(BASE_ADDR + m_idx); m_wr = 1;
          end
        end else begin
          m_loading = 0;
          if (m_xor == 8'h00) m_done = 1; else m_err = 1;
        end
      end
    end
  end

  logic [31:0] wr_addr[$];
  logic [15:0] wr_data[$];

  // Per-cycle comparison against the model, plus write log.
  initial forever begin
    @(negedge clk_i);
    chk("byte_ready", 32'(bus.byte_ready_o), 32'(m_loading && !m_wr));
    chk("write_en", 32'(bus.program_mem_write_en_o), 32'(e_we));
    chk("instruction", 32'(bus.instruction_o), 32'(e_instr));
    chk("instruction_addr", bus.instruction_addr_o, e_addr);
    chk("cpu_reset", 32'(cpu_reset_o), 32'(!m_done));
    chk("busy", 32'(busy_o), 32'(m_loading));
    chk("load_done", 32'(load_done_o), 32'(m_done));
    chk("load_error", 32'(load_error_o), 32'(m_err));
    if (bus.program_mem_write_en_o) begin
      wr_addr.push_back(bus.instruction_addr_o);
      wr_data.push_back(bus.instruction_o);
    end
  end

  task automatic pulse_start();
    @(negedge clk_i);
    start_i = 1'b1;
    wr_addr.delete();
    wr_data.delete();
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      bus.byte_valid_i = 1'b0;
      bus.byte_i       = 8'($urandom);
    end
  endtask

  // Present a byte until accepted; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk_i);
    bus.byte_valid_i = 1'b1;
    bus.byte_i       = b;
    #1;
    while (!bus.byte_ready_o && t < 20) begin
      @(negedge clk_i);
      #1;
      t++;
    end
    chk("byte_accept_timeout", 32'(bus.byte_ready_o), 32'd1);
    @(posedge clk_i);
  endtask

  task automatic send_stream(input logic [7:0] q[$], input bit gaps);
    foreach (q[i]) begin
      if (gaps) idle(int'($urandom_range(0, 3)));
      send_byte(q[i]);
    end
    idle(1);
  endtask

  task automatic wait_end();
    int t = 0;
    while (!(load_done_o || load_error_o) && t < 100) begin
      @(negedge clk_i);
      #2;
      t++;
    end
    chk("load_finish_timeout", 32'(load_done_o || load_error_o), 32'd1);
  endtask

  task automatic chk_image1(input string tag);
    chk({tag, "_write_count"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() >= 2) begin
      chk({tag, "_addr0"}, wr_addr[0], 32'd0);
      chk({tag, "_data0"}, 32'(wr_data[0]), 32'h1234);
      chk({tag, "_addr1"}, wr_addr[1], 32'd1);
      chk({tag, "_data1"}, 32'(wr_data[1]), 32'h5678);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(bus.byte_ready_o), 32'd0);
    chk({tag, "_we"}, 32'(bus.program_mem_write_en_o), 32'd0);
    chk({tag, "_instr"}, 32'(bus.instruction_o), 32'd0);
    chk({tag, "_addr"}, bus.instruction_addr_o, 32'(BASE_ADDR));
    chk({tag, "_cpu_reset"}, 32'(cpu_reset_o), 32'd1);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done"}, 32'(load_done_o), 32'd0);
    chk({tag, "_error"}, 32'(load_error_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] img1[$];
    logic [7:0] hdr0[$];
    logic [7:0] big[$];
    logic [7:0] x;
    bus.byte_valid_i = 1'b0;
    bus.byte_i       = '0;
    img1 = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    hdr0 = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    img1.push_back(8'h0A);
    hdr0.push_back(8'h00);
`endif

    #1 reset_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #3;
    chk_reset_vals("reset");
    @(negedge clk_i);
    #2 reset_i = 1'b0;

    // Basic two half-word image with exact write/done timing.
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(img1[i]);
    send_byte(img1[5]);
    @(negedge clk_i);
    #1;
    chk("t1_we_after_hi", 32'(bus.program_mem_write_en_o), 32'd1);
    chk("t1_instr_after_hi", 32'(bus.instruction_o), 32'h5678);
    chk("t1_addr_after_hi", bus.instruction_addr_o, 32'd1);
    chk("t1_done_early", 32'(load_done_o), 32'd0);
`ifndef LOADER_CHECKSUM_EN
    @(negedge clk_i);
    #1;
    chk("t1_done_t2", 32'(load_done_o), 32'd1);
    chk("t1_cpu_reset_t2", 32'(cpu_reset_o), 32'd0);
    chk("t1_busy_t2", 32'(busy_o), 32'd0);
`else
    send_byte(img1[6]);
`endif
    idle(1);
    wait_end();
    chk_image1("t1");

    // Zero-length image.
    pulse_start();
    send_stream(hdr0, 1'b0);
    wait_end();
    chk("t2_done", 32'(load_done_o), 32'd1);
    chk("t2_write_count", 32'(wr_addr.size()), 32'd0);

    // Oversize length 0x201 aborts.
    pulse_start();
    send_stream('{8'h01, 8'h02}, 1'b0);
    wait_end();
    chk("t3_error", 32'(load_error_o), 32'd1);
    chk("t3_cpu_reset", 32'(cpu_reset_o), 32'd1);
    chk("t3_done", 32'(load_done_o), 32'd0);
    chk("t3_write_count", 32'(wr_addr.size()), 32'd0);

    // Recovery from ERR with a gappy stream.
    pulse_start();
    send_stream(img1, 1'b1);
    wait_end();
    chk("t4_done", 32'(load_done_o), 32'd1);
    chk_image1("t4");

    // Reset in the middle of DATA_HI, then a clean load.
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h34);
    @(negedge clk_i);
    #2 reset_i = 1'b1;
    #1;
    chk_reset_vals("t5_midload_reset");
    bus.byte_valid_i = 1'b0;
    @(negedge clk_i);
    #2 reset_i = 1'b0;
    pulse_start();
    send_stream(img1, 1'b0);
    wait_end();
    chk("t5_done", 32'(load_done_o), 32'd1);
    chk_image1("t5");

    // Full-depth image (N == 512) is legal.
    big = '{8'h00, 8'h02};
    x   = 8'h02;
    for (int i = 0; i < 512; i++) begin
      big.push_back(8'(i));
      big.push_back(8'(i >> 8) ^ 8'hA5);
      x ^= 8'(i) ^ 8'(i >> 8) ^ 8'hA5;
    end
`ifdef LOADER_CHECKSUM_EN
    big.push_back(x);
`endif
    pulse_start();
    send_stream(big, 1'b0);
    wait_end();
    chk("full_done", 32'(load_done_o), 32'd1);
    chk("full_write_count", 32'(wr_addr.size()), 32'd512);
    if (wr_addr.size() == 512) begin
      chk("full_data0", 32'(wr_data[0]), 32'hA500);
      chk("full_addr_last", wr_addr[511], 32'd511);
      chk("full_data_last", 32'(wr_data[511]), 32'hA4FF);
    end

`ifdef LOADER_CHECKSUM_EN
    // Checksum accept and reject.
    pulse_start();
    send_stream('{8'h01, 8'h00, 8'hAA, 8'h55, 8'hFE}, 1'b0);
    wait_end();
    chk("t6_good_done", 32'(load_done_o), 32'd1);
    chk("t6_good_data", (wr_data.size() == 1) ? 32'(wr_data[0]) : 32'hFFFF_FFFF, 32'h55AA);
    pulse_start();
    send_stream('{8'h01, 8'h00, 8'hAA, 8'h55, 8'h00}, 1'b0);
    wait_end();
    chk("t6_bad_error", 32'(load_error_o), 32'd1);
    chk("t6_bad_cpu_reset", 32'(cpu_reset_o), 32'd1);
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
